// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT driving datapath strobes.
// Build option: define MC_CTRL_ADDI_EN to decode opcode 0x08 as addi (otherwise it is illegal).
module mc_ctrl #(
   parameter int MAX_INSTR = 11,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ins,
   input  logic             zero,
   output logic             irLoad,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic [2:0]       op,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Mem2Reg,
   output logic [1:0]       PCsel,
   output logic             PCload,
   output logic             illegal,
   output logic             done,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INSTR);
   localparam bit               HALT_EN = (MAX_INSTR != 0);

`ifdef MC_CTRL_ADDI_EN
   localparam bit ADDI_EN = 1'b1;
`else
   localparam bit ADDI_EN = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [5:0]       funct_q, funct_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             illegal_q, illegal_d;

   // Only the opcode and funct fields matter to the sequencer.
   logic ins_unused;
   assign ins_unused = ^ins[25:6];

   logic       is_r, is_addi, is_lw, is_sw, is_beq, is_j, r_ok, legal;
   logic [2:0] r_op;

   always_comb begin
      r_op = 3'd0;
      r_ok = 1'b1;
      case (funct_q)
         6'h20:   r_op = 3'd2;
         6'h22:   r_op = 3'd6;
         6'h24:   r_op = 3'd0;
         6'h25:   r_op = 3'd1;
         6'h2A:   r_op = 3'd7;
         default: r_ok = 1'b0;
      endcase
   end

   assign is_r    = (opcode_q == 6'h00);
   assign is_addi = ADDI_EN && (opcode_q == 6'h08);
   assign is_lw   = (opcode_q == 6'h23);
   assign is_sw   = (opcode_q == 6'h2B);
   assign is_beq  = (opcode_q == 6'h04);
   assign is_j    = (opcode_q == 6'h02);
   assign legal   = (is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

   logic       s_irload, s_regdst, s_regwrite, s_alusrc;
   logic       s_memread, s_memwrite, s_mem2reg, s_pcload, retire;
   logic [2:0] s_op;
   logic [1:0] s_pcsel;

   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      funct_d    = funct_q;
      retired_d  = retired_q;
      illegal_d  = illegal_q;
      s_irload   = 1'b0;
      s_regdst   = 1'b0;
      s_regwrite = 1'b0;
      s_alusrc   = 1'b0;
      s_memread  = 1'b0;
      s_memwrite = 1'b0;
      s_mem2reg  = 1'b0;
      s_pcload   = 1'b0;
      s_op       = 3'd0;
      s_pcsel    = 2'd0;
      retire     = 1'b0;

      case (state_q)
         S_FETCH: begin
            s_irload = 1'b1;
            opcode_d = ins[31:26];
            funct_d  = ins[5:0];
            state_d  = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (!legal) begin
               // Unsupported encodings complete as a NOP and flag it.
               s_pcload  = 1'b1;
               retire    = 1'b1;
               illegal_d = 1'b1;
            end else if (is_r) begin
               s_op    = r_op;
               state_d = S_WB;
            end else if (is_addi) begin
               s_op     = 3'd2;
               s_alusrc = 1'b1;
               state_d  = S_WB;
            end else if (is_lw || is_sw) begin
               s_op     = 3'd2;
               s_alusrc = 1'b1;
               state_d  = S_MEM;
            end else if (is_beq) begin
               s_op     = 3'd6;
               s_pcsel  = {1'b0, zero};
               s_pcload = 1'b1;
               retire   = 1'b1;
            end else begin
               s_pcsel  = 2'd2;
               s_pcload = 1'b1;
               retire   = 1'b1;
            end
         end
         S_MEM: begin
            if (is_lw) begin
               s_memread = 1'b1;
               state_d   = S_WB;
            end else begin
               s_memwrite = 1'b1;
               s_pcload   = 1'b1;
               retire     = 1'b1;
            end
         end
         S_WB: begin
            s_regwrite = 1'b1;
            s_regdst   = is_r;
            s_mem2reg  = is_lw;
            s_pcload   = 1'b1;
            retire     = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase

      if (retire) begin
         retired_d = retired_q + CNT_ONE;
         state_d   = (HALT_EN && (retired_d == CNT_MAX)) ? S_HALT : S_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         opcode_q  <= 6'd0;
         funct_q   <= 6'd0;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         funct_q   <= funct_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   // Every output reads zero for as long as rst is held, not just after the edge.
   assign irLoad    = s_irload & ~rst;
   assign RegDst    = s_regdst & ~rst;
   assign RegWrite  = s_regwrite & ~rst;
   assign ALUSrc    = s_alusrc & ~rst;
   assign op        = rst ? 3'd0 : s_op;
   assign MemRead   = s_memread & ~rst;
   assign MemWrite  = s_memwrite & ~rst;
   assign Mem2Reg   = s_mem2reg & ~rst;
   assign PCsel     = rst ? 2'd0 : s_pcsel;
   assign PCload    = s_pcload & ~rst;
   assign illegal   = illegal_q & ~rst;
   assign done      = (state_q == S_HALT) & ~rst;
   assign retired   = rst ? '0 : retired_q;
   assign dbg_state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction expectations from an ISA-level model.
module tb_mc_ctrl;
   localparam int MAXI  = 11;
   localparam int CNT_W = 16;

   logic             clk, rst, zero;
   logic [31:0]      ins;
   logic             irLoad, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, PCload;
   logic             illegal, done;
   logic [2:0]       op, dbg_state;
   logic [1:0]       PCsel;
   logic [CNT_W-1:0] retired;

   mc_ctrl #(.MAX_INSTR(MAXI), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ins(ins), .zero(zero),
      .irLoad(irLoad), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
      .op(op), .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg),
      .PCsel(PCsel), .PCload(PCload), .illegal(illegal), .done(done),
      .retired(retired), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  cyc;
      logic [1:0]  pcsel;
      logic        rw, rd, m2r, mr, mw;
      logic [2:0]  op;
      logic        alusrc;
      logic        ill;
      logic [15:0] ret;
   } exp_t;

   logic [31:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int m_count;
   bit m_ill;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: one summary record per instruction
   task automatic push_expected(input logic [31:0] w, input logic z);
      exp_t e;
      logic [5:0] opc, fn;
      logic [2:0] rop;
      bit ok, addi_en;
      opc = w[31:26];
      fn  = w[5:0];
      ok  = 1'b1;
      rop = 3'd0;
`ifdef MC_CTRL_ADDI_EN
      addi_en = 1'b1;
`else
      addi_en = 1'b0;
`endif
      e = '0;
      e.ill = m_ill;
      if (opc == 6'h00) begin
         if      (fn == 6'h20) rop = 3'd2;
         else if (fn == 6'h22) rop = 3'd6;
         else if (fn == 6'h24) rop = 3'd0;
         else if (fn == 6'h25) rop = 3'd1;
         else if (fn == 6'h2A) rop = 3'd7;
         else ok = 1'b0;
         if (ok) begin e.cyc = 4; e.rw = 1; e.rd = 1; e.op = rop; end
      end else if (opc == 6'h08 && addi_en) begin
         e.cyc = 4; e.rw = 1; e.op = 3'd2; e.alusrc = 1;
      end else if (opc == 6'h23) begin
         e.cyc = 5; e.mr = 1; e.rw = 1; e.m2r = 1; e.op = 3'd2; e.alusrc = 1;
      end else if (opc == 6'h2B) begin
         e.cyc = 4; e.mw = 1; e.op = 3'd2; e.alusrc = 1;
      end else if (opc == 6'h04) begin
         e.cyc = 3; e.op = 3'd6; e.pcsel = z ? 2'd1 : 2'd0;
      end else if (opc == 6'h02) begin
         e.cyc = 3; e.pcsel = 2'd2;
      end else begin
         ok = 1'b0;
      end
      if (!ok) e.cyc = 3;
      m_count = (m_count + 1) % 65536;
      e.ret = m_count[15:0];
      if (!ok) m_ill = 1'b1;
      exp_q.push_back(e);
   endtask

   // driver tasks
   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      m_count = 0;
      m_ill   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic issue(input logic [31:0] w, input logic z);
      int n;
      n = 0;
      @(negedge clk);
      while (irLoad !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (irLoad !== 1'b1) chk("fetch_timeout", irLoad, 1);
      else begin
         ins  = w;
         zero = z;
         push_expected(w, z);
      end
   endtask

   function automatic logic [31:0] rand_ins();
      logic [31:0] b;
      logic [5:0]  ft [5];
      logic [5:0]  opc, fn;
      ft = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      b  = $urandom;
      fn = b[5:0];
      case ($urandom_range(0, 7))
         0: begin opc = 6'h00; fn = ft[$urandom_range(0, 4)]; end
         1: opc = 6'h00;
         2: opc = 6'h08;
         3: opc = 6'h23;
         4: opc = 6'h2B;
         5: opc = 6'h04;
         6: opc = 6'h02;
         default: opc = b[31:26];
      endcase
      return {opc, b[25:6], fn};
   endfunction

   bit active = 1'b0;
   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || active) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      @(negedge clk);
   endtask

   // monitor / scoreboard
   int         acc_cyc;
   logic       acc_rw, acc_rd, acc_m2r, acc_mr, acc_mw, acc_alusrc, acc_ill;
   logic [2:0] acc_op;
   bit         ret_pend = 1'b0;
   logic [15:0] ret_exp;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("reset_outputs", {irLoad, RegDst, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
                               PCsel, PCload, illegal, done, retired, dbg_state}, 0);
         active   = 1'b0;
         ret_pend = 1'b0;
      end else begin
         if (ret_pend) begin
            chk("retired", retired, ret_exp);
            chk("done_after_retire", done, (ret_exp == MAXI[15:0]));
            ret_pend = 1'b0;
         end
         if (irLoad) begin
            chk("fetch_overlap", active, 0);
            active  = 1'b1;
            acc_cyc = 1;
            acc_rw = 0; acc_rd = 0; acc_m2r = 0; acc_mr = 0; acc_mw = 0;
            acc_op = 0; acc_alusrc = 0;
            acc_ill = illegal;
         end else if (active) begin
            acc_cyc++;
         end
         if (active) begin
            if (RegWrite) begin acc_rw = 1; acc_rd = RegDst; acc_m2r = Mem2Reg; end
            acc_mr = acc_mr | MemRead;
            acc_mw = acc_mw | MemWrite;
            if (acc_cyc == 3) begin acc_op = op; acc_alusrc = ALUSrc; end
         end
         if (PCload) begin
            chk("pcload_in_instr", active, 1);
            if (active) begin
               chk("queue_nonempty", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("cycles", acc_cyc, e.cyc);
                  chk("pcsel", PCsel, e.pcsel);
                  chk("regwrite", acc_rw, e.rw);
                  chk("regdst", acc_rd, e.rd);
                  chk("mem2reg", acc_m2r, e.m2r);
                  chk("memread", acc_mr, e.mr);
                  chk("memwrite", acc_mw, e.mw);
                  chk("alu_op", acc_op, e.op);
                  chk("alusrc", acc_alusrc, e.alusrc);
                  chk("illegal_sticky", acc_ill, e.ill);
                  ret_exp  = e.ret;
                  ret_pend = 1'b1;
               end
               active = 1'b0;
            end
         end
         if (active && acc_cyc > 8) begin
            chk("cycle_budget", acc_cyc, 8);
            active = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      bad++;
      $display("FAIL watchdog: time %0t expired", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rst = 1'b1; ins = 32'd0; zero = 1'b0;
      m_count = 0; m_ill = 1'b0;

      // directed: test-plan instruction mix
      do_reset();
      issue(32'h012A4020, 1'b0);
      issue(32'h8D090004, 1'b0);
      issue(32'hAD090008, 1'b0);
      issue(32'h11090002, 1'b1);
      issue(32'h11090002, 1'b0);
      issue(32'h08000020, 1'b0);
      issue(32'h21090005, 1'b0);
      issue(32'h012A4020, 1'b0);
      wait_idle();

      // halt after MAX_INSTR retirements, then hold
      do_reset();
      for (int i = 0; i < MAXI; i++) issue({6'h00, $urandom_range(0, 1048575), 6'h20} , 1'b0);
      wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_done", done, 1);
         chk("halt_retired", retired, MAXI);
         chk("halt_quiet", {irLoad, PCload, RegWrite}, 0);
      end

      // reset during EXEC of lw
      do_reset();
      issue(32'h8D090004, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      m_count = 0;
      m_ill   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("post_reset_irload", irLoad, 1);
      chk("post_reset_retired", retired, 0);
      chk("post_reset_memread", MemRead, 0);
      issue(32'hAD090008, 1'b0);
      wait_idle();

      // randomized segments
      for (int s = 0; s < 14; s++) begin
         int n;
         do_reset();
         n = $urandom_range(1, MAXI);
         for (int i = 0; i < n; i++) issue(rand_ins(), 1'($urandom_range(0, 1)));
         wait_idle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
